uart_alu_interface: RTL and testbench
=====================================

UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

Interface
REQ-001 Parameter NB_DATA_BUS, default 8, SHALL set the width of operands, result and UART data bytes.
REQ-002 Parameter NB_OPCODE, default 6, SHALL set the ALU opcode width.
REQ-003 i_clock  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 i_reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_rx_data  input  NB_DATA_BUS  SHALL carry the received UART byte, valid when i_rx_done is high.
REQ-006 i_rx_done  input  1  SHALL be a one-cycle pulse marking a new received byte.
REQ-007 i_alu_result  input  NB_DATA_BUS  SHALL carry the combinational ALU result.
REQ-008 i_tx_busy  input  1  SHALL be high while the UART transmitter is sending.
REQ-009 o_first_operator  output  NB_DATA_BUS  SHALL drive the ALU first operand (registered).
REQ-010 o_second_operator  output  NB_DATA_BUS  SHALL drive the ALU second operand (registered).
REQ-011 o_opcode  output  NB_OPCODE  SHALL drive the ALU opcode (registered).
REQ-012 o_tx_data  output  NB_DATA_BUS  SHALL carry the byte to transmit (registered).
REQ-013 o_tx_start  output  1  SHALL be a registered one-cycle pulse requesting transmission of o_tx_data.

Function
REQ-014 The FSM SHALL have exactly five states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE and SEND.
REQ-015 In WAIT_A, on i_rx_done, the block SHALL load o_first_operator with i_rx_data and go to WAIT_B.
REQ-016 In WAIT_B, on i_rx_done, the block SHALL load o_second_operator with i_rx_data and go to WAIT_OP.
REQ-017 In WAIT_OP, on i_rx_done, the block SHALL load o_opcode with i_rx_data[NB_OPCODE-1:0], discard the upper bits, and go to COMPUTE.
REQ-018 Without i_rx_done, WAIT_A, WAIT_B and WAIT_OP SHALL hold state and all registers.
REQ-019 COMPUTE SHALL last exactly one cycle, load o_tx_data with i_alu_result at its closing edge, and go to SEND.
REQ-020 In SEND with i_tx_busy high, the block SHALL hold state with o_tx_start low.
REQ-021 In SEND with i_tx_busy low, the block SHALL set o_tx_start high for exactly one cycle and go to WAIT_A.
REQ-022 Latency: with the opcode byte sampled at edge k and i_tx_busy low, o_tx_start SHALL be high between edges k+2 and k+3.
REQ-023 i_rx_done pulses in COMPUTE or SEND SHALL be ignored; the byte is dropped and no register changes.
REQ-024 Operand and opcode registers SHALL hold until overwritten in their own state; they are not cleared after a transaction.
REQ-025 o_tx_data SHALL remain stable from COMPUTE's closing edge until the next COMPUTE.
REQ-026 Undefined opcodes SHALL be forwarded unchanged; whatever i_alu_result returns (0 for undefined) SHALL be transmitted.
REQ-027 The block SHALL perform no arithmetic itself; the result byte is passed through bit-exact.

Reset
REQ-028 i_reset high SHALL immediately force state WAIT_A and clear o_first_operator, o_second_operator, o_opcode, o_tx_data and o_tx_start to 0, independent of i_clock.
REQ-029 Reset asserted mid-sequence (any state, including SEND) SHALL abort the transaction; no o_tx_start pulse SHALL follow.
REQ-030 After reset release, the first i_rx_done SHALL be treated as operand A.

Verification
REQ-031 Bytes 0x05, 0x03, 0x20 with ALU result 0x08, i_tx_busy low -> operands 0x05/0x03, opcode 0x20, o_tx_data 0x08, single o_tx_start at edge k+2.
REQ-032 Bytes 0x03, 0x05, 0x22 with i_alu_result 0xFE -> o_tx_data 0xFE; opcode byte 0xE3 -> o_opcode 0x23.
REQ-033 i_tx_busy held high for 4 cycles after entering SEND -> o_tx_start fires on the first cycle busy is low, exactly once.
REQ-034 i_rx_done pulse with 0xAA during COMPUTE and SEND -> all registers unchanged; next byte after return to WAIT_A loads operand A.
REQ-035 Reset asserted after operand B 0x11 loaded -> all outputs 0 within the same cycle, state WAIT_A, no o_tx_start.
REQ-036 Two back-to-back full transactions (0x80,0x02,0x03 then 0x0F,0xF0,0x25) -> two o_tx_start pulses carrying the respective i_alu_result values in order.

Source files
------------

// File: rtl/uart_alu_interface.sv
// Glue between a byte-oriented UART and a combinational ALU: collects operand A,
// operand B and an opcode byte, captures the ALU result, then requests one transmission.
module uart_alu_interface #(
    parameter int NB_DATA_BUS = 8,
    parameter int NB_OPCODE   = 6
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_DATA_BUS-1:0] i_rx_data,
    input  logic                   i_rx_done,
    input  logic [NB_DATA_BUS-1:0] i_alu_result,
    input  logic                   i_tx_busy,
    output logic [NB_DATA_BUS-1:0] o_first_operator,
    output logic [NB_DATA_BUS-1:0] o_second_operator,
    output logic [NB_OPCODE-1:0]   o_opcode,
    output logic [NB_DATA_BUS-1:0] o_tx_data,
    output logic                   o_tx_start
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic [NB_DATA_BUS-1:0] first_r, first_s;
    logic [NB_DATA_BUS-1:0] second_r, second_s;
    logic [NB_OPCODE-1:0]   opcode_r, opcode_s;
    logic [NB_DATA_BUS-1:0] tx_data_r, tx_data_s;
    logic                   tx_start_r, tx_start_s;

    // Next-state and next-register values; bytes arriving in COMPUTE/SEND are dropped.
    always_comb begin
        state_s    = state_r;
        first_s    = first_r;
        second_s   = second_r;
        opcode_s   = opcode_r;
        tx_data_s  = tx_data_r;
        tx_start_s = 1'b0;
        case (state_r)
            WAIT_A: begin
                if (i_rx_done) begin
                    first_s = i_rx_data;
                    state_s = WAIT_B;
                end else begin
                    state_s = WAIT_A;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    second_s = i_rx_data;
                    state_s  = WAIT_OP;
                end else begin
                    state_s = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    opcode_s = i_rx_data[NB_OPCODE-1:0];
                    state_s  = COMPUTE;
                end else begin
                    state_s = WAIT_OP;
                end
            end
            COMPUTE: begin
                // Operands and opcode have been stable for a full cycle here.
                tx_data_s = i_alu_result;
                state_s   = SEND;
            end
            SEND: begin
                if (i_tx_busy) begin
                    state_s = SEND;
                end else begin
                    tx_start_s = 1'b1;
                    state_s    = WAIT_A;
                end
            end
            default: begin
                state_s = WAIT_A;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= WAIT_A;
            first_r    <= {NB_DATA_BUS{1'b0}};
            second_r   <= {NB_DATA_BUS{1'b0}};
            opcode_r   <= {NB_OPCODE{1'b0}};
            tx_data_r  <= {NB_DATA_BUS{1'b0}};
            tx_start_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            first_r    <= first_s;
            second_r   <= second_s;
            opcode_r   <= opcode_s;
            tx_data_r  <= tx_data_s;
            tx_start_r <= tx_start_s;
        end
    end

    assign o_first_operator  = first_r;
    assign o_second_operator = second_r;
    assign o_opcode          = opcode_r;
    assign o_tx_data         = tx_data_r;
    assign o_tx_start        = tx_start_r;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: a small behavioural ALU answers the
// DUT's operands, and each transaction's expectations come from the bytes sent.
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] alu_result;
    logic       tx_busy = 1'b0;
    logic [7:0] first_op, second_op, tx_data;
    logic [5:0] opcode;
    logic       tx_start;

    logic       force_en = 1'b0;
    logic [7:0] force_val = 8'h00;
    int         n_checks = 0;
    int         n_fail = 0;
    int         pulses = 0;

    always #5 clk = ~clk;

    uart_alu_interface #(.NB_DATA_BUS(8), .NB_OPCODE(6)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_rx_data        (rx_data),
        .i_rx_done        (rx_done),
        .i_alu_result     (alu_result),
        .i_tx_busy        (tx_busy),
        .o_first_operator (first_op),
        .o_second_operator(second_op),
        .o_opcode         (opcode),
        .o_tx_data        (tx_data),
        .o_tx_start       (tx_start)
    );

    // Behavioural ALU: a handful of defined opcodes, zero for anything else.
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return sa >>> b[2:0];
            6'h02:   return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = force_en ? force_val : ref_alu(first_op, second_op, opcode);

    // Count cycles in which a transmit request is visible.
    always @(posedge clk) begin
        #2;
        if (tx_start === 1'b1) pulses++;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // One full A/B/opcode transaction followed by the transmit handshake.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int busy, input int gap, input bit inject,
                           input bit fen, input logic [7:0] fval);
        logic [7:0] exp_res;
        logic [5:0] exp_op;
        int lat;
        int p0;
        exp_op  = op[5:0];
        exp_res = fen ? fval : ref_alu(a, b, exp_op);
        force_en  = fen;
        force_val = fval;
        tx_busy   = 1'b0;
        p0 = pulses;
        repeat (gap) @(negedge clk);
        send_byte(a);
        n_checks++;
        if (first_op !== a) begin n_fail++; $display("FAIL load_a: got %h expected %h", first_op, a); end
        repeat (gap) @(negedge clk);
        send_byte(b);
        n_checks++;
        if (second_op !== b || first_op !== a) begin
            n_fail++; $display("FAIL load_b: got %h/%h expected %h/%h", first_op, second_op, a, b);
        end
        repeat (gap) @(negedge clk);
        tx_busy = (busy > 0);
        send_byte(op);
        n_checks++;
        if (opcode !== exp_op || tx_start !== 1'b0) begin
            n_fail++; $display("FAIL load_op: opcode %h start %b expected %h 0", opcode, tx_start, exp_op);
        end
        if (inject) begin rx_data = 8'hAA; rx_done = 1'b1; end
        @(negedge clk);
        rx_done = 1'b0;
        n_checks++;
        if (tx_data !== exp_res || tx_start !== 1'b0) begin
            n_fail++; $display("FAIL result: tx_data %h start %b expected %h 0", tx_data, tx_start, exp_res);
        end
        for (int i = 0; i < busy; i++) begin
            if (inject && i == 0) begin rx_data = 8'hAA; rx_done = 1'b1; end
            @(negedge clk);
            rx_done = 1'b0;
            n_checks++;
            if (tx_start !== 1'b0 || first_op !== a || second_op !== b || opcode !== exp_op || tx_data !== exp_res) begin
                n_fail++;
                $display("FAIL busy_hold: start %b regs %h %h %h %h expected 0 %h %h %h %h",
                         tx_start, first_op, second_op, opcode, tx_data, a, b, exp_op, exp_res);
            end
        end
        tx_busy = 1'b0;
        lat = 0;
        while (tx_start !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 1 || tx_data !== exp_res) begin
            n_fail++; $display("FAIL start_latency: cycles %0d data %h expected 1 %h", lat, tx_data, exp_res);
        end
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0 || pulses - p0 != 1) begin
            n_fail++; $display("FAIL single_pulse: start %b pulses %0d expected 0 1", tx_start, pulses - p0);
        end
        n_checks++;
        if (first_op !== a || second_op !== b || opcode !== exp_op || tx_data !== exp_res) begin
            n_fail++;
            $display("FAIL retain: %h %h %h %h expected %h %h %h %h",
                     first_op, second_op, opcode, tx_data, a, b, exp_op, exp_res);
        end
        force_en = 1'b0;
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (first_op !== 8'h00 || second_op !== 8'h00 || opcode !== 6'h00 || tx_data !== 8'h00 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: outputs %h %h %h %h %b expected all zero", name, first_op, second_op, opcode, tx_data, tx_start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_release");
    endtask

    task automatic test_basic();
        run_txn(8'h05, 8'h03, 8'h20, 0, 0, 1'b0, 1'b0, 8'h00);
        run_txn(8'h03, 8'h05, 8'h22, 0, 1, 1'b0, 1'b1, 8'hFE);
        run_txn(8'h03, 8'h05, 8'hE3, 0, 0, 1'b0, 1'b0, 8'h00);
        run_txn(8'h12, 8'h34, 8'h3F, 0, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_busy();
        run_txn(8'h44, 8'h0F, 8'h24, 4, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_ignore();
        run_txn(8'h21, 8'h42, 8'h26, 2, 0, 1'b1, 1'b0, 8'h00);
        send_byte(8'h5A);
        n_checks++;
        if (first_op !== 8'h5A || second_op !== 8'h42) begin
            n_fail++; $display("FAIL after_ignore: a %h b %h expected 5a 42", first_op, second_op);
        end
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int p0;
        send_byte(8'h05);
        send_byte(8'h11);
        n_checks++;
        if (second_op !== 8'h11) begin n_fail++; $display("FAIL mid_load_b: got %h expected 11", second_op); end
        p0 = pulses;
        rst = 1'b1;
        #1;
        check_zero("async_reset_wait_op");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("post_reset_idle");
        tx_busy = 1'b1;
        send_byte(8'h09);
        send_byte(8'h07);
        send_byte(8'h25);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("async_reset_send");
        @(negedge clk);
        rst = 1'b0;
        tx_busy = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (pulses != p0) begin n_fail++; $display("FAIL aborted_send: pulses %0d expected 0", pulses - p0); end
        send_byte(8'h77);
        n_checks++;
        if (first_op !== 8'h77 || second_op !== 8'h00) begin
            n_fail++; $display("FAIL first_after_reset: a %h b %h expected 77 00", first_op, second_op);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_txn(8'h80, 8'h02, 8'h03, 0, 0, 1'b0, 1'b0, 8'h00);
        run_txn(8'h0F, 8'hF0, 8'h25, 0, 0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] op;
            op = (i % 2 == 0) ? 8'($urandom_range(32, 39)) | 8'($urandom_range(0, 3) << 6) : 8'($urandom);
            run_txn(8'($urandom), 8'($urandom), op, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)) & 1'(i % 3 == 0), 1'(i % 5 == 4), 8'($urandom));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_busy();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
